// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: frame-aligned on_time updates, settle wait, one-cycle done pulse.
// Optional build macro SERVO_PWM_GEN_SKIP_SAME_EN: a trigger that repeats the active on_time completes at once.
module servo_pwm_gen #(
  parameter int PWM_BITS      = 16,
  parameter int PERIOD        = 20000,
  parameter int SETTLE_FRAMES = 25,
  parameter int RESET_ON_TIME = 1500
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  input  logic                trigger,
  input  logic [PWM_BITS-1:0] on_time,
  output logic                rdy,
  output logic                done,
  output logic                pwm_out
);

  localparam int SW = (SETTLE_FRAMES < 2) ? 1 : $clog2(SETTLE_FRAMES + 1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_FRAME = 2'd1;
  localparam logic [1:0] SETTLE     = 2'd2;
  localparam logic [1:0] DONE       = 2'd3;

  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] active_on_time;
  logic [PWM_BITS-1:0] pending;
  logic [SW-1:0]       settle_cnt;
  logic [1:0]          state;
  logic                boundary;
  logic                skip;

  assign boundary = clk_en && (cnt == PWM_BITS'(PERIOD - 1));
  assign rdy      = (state == IDLE);
  assign done     = (state == DONE);

`ifdef SERVO_PWM_GEN_SKIP_SAME_EN
  assign skip = (on_time == active_on_time);
`else
  assign skip = 1'b0;
`endif

  // Compare uses the pre-increment count, so the output is one clk behind cnt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      pwm_out <= 1'b0;
    end else if (clk_en) begin
      pwm_out <= (cnt < active_on_time);
      cnt     <= boundary ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      pending        <= '0;
      active_on_time <= PWM_BITS'(RESET_ON_TIME);
      settle_cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (trigger) begin
          pending <= on_time;
          state   <= skip ? DONE : WAIT_FRAME;
        end
        // The boundary cycle still drives the old value; cnt=0 is the first under the new one.
        WAIT_FRAME: if (boundary) begin
          active_on_time <= pending;
          settle_cnt     <= '0;
          state          <= (SETTLE_FRAMES == 0) ? DONE : SETTLE;
        end
        SETTLE: if (boundary) begin
          settle_cnt <= settle_cnt + 1'b1;
          if (int'(settle_cnt) + 1 >= SETTLE_FRAMES) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Randomized bench for servo_pwm_gen against a frame/boundary-counting reference model.
module tb_servo_pwm_gen;
  localparam int PB  = 16;
  localparam int PER = 100;
  localparam int SF  = 2;
  localparam int ROT = 30;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clk_en = 1'b1;
  logic          trigger = 1'b0;
  logic [PB-1:0] on_time = '0;
  logic          rdy, done, pwm_out;

  always #5 clk = ~clk;

  servo_pwm_gen #(.PWM_BITS(PB), .PERIOD(PER), .SETTLE_FRAMES(SF), .RESET_ON_TIME(ROT)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .trigger(trigger),
    .on_time(on_time), .rdy(rdy), .done(done), .pwm_out(pwm_out)
  );

  int checks = 0, errors = 0;
  int cyc_n = 0, dut_dones = 0, m_dones = 0, last_done_cyc = -1;
  int en_mode = 0;

  // Reference model: ticks since reset, active/pending values, boundaries still to see.
  int m_ticks, m_active, m_pend, m_bleft;
  bit m_busy, m_done, m_pwm;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ticks = 0; m_active = ROT; m_pend = 0; m_bleft = 0;
    m_busy = 0; m_done = 0; m_pwm = 0;
  endtask

  task automatic model_step();
    int ph;
    bit bnd;
    ph  = m_ticks % PER;
    bnd = clk_en && (ph == PER - 1);
    if (clk_en) m_pwm = (ph < m_active);
    if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (!m_busy) begin
      if (trigger) begin
        m_busy = 1; m_pend = int'(on_time); m_bleft = SF + 1;
`ifdef SERVO_PWM_GEN_SKIP_SAME_EN
        if (int'(on_time) == m_active) begin m_bleft = 0; m_done = 1; m_dones++; end
`endif
      end
    end else if (bnd) begin
      if (m_bleft == SF + 1) m_active = m_pend;
      m_bleft--;
      if (m_bleft == 0) begin m_done = 1; m_dones++; end
    end
    if (clk_en) m_ticks++;
  endtask

  task automatic cyc();
    @(posedge clk);
    cyc_n++;
    model_step();
    #1;
    chk("pwm_out", pwm_out, m_pwm);
    chk("rdy", rdy, !m_busy);
    chk("done", done, m_done);
    if (done === 1'b1) begin dut_dones++; last_done_cyc = cyc_n; end
    case (en_mode)
      1:       clk_en = ((cyc_n + 1) % 4 == 0);
      2:       clk_en = 1'($urandom_range(0, 1));
      default: clk_en = 1'b1;
    endcase
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic go_trig(input int v);
    on_time = PB'(v);
    trigger = 1'b1;
    cyc();
    trigger = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (rdy !== 1'b1 && n < budget) begin cyc(); n++; end
    chk("wait_rdy", rdy, 1);
  endtask

  task automatic wait_phase(input int p, input int budget);
    int n = 0;
    while ((m_ticks % PER) != p && n < budget) begin cyc(); n++; end
    chk("wait_phase", m_ticks % PER, p);
  endtask

  initial begin
    int d0, t0, n;
    model_reset();
    #12;
    chk("rst_rdy", rdy, 1);
    chk("rst_done", done, 0);
    chk("rst_pwm", pwm_out, 0);
    @(posedge clk); #1 reset = 1'b1;

    // Idle: reset on_time pulses only.
    run(250);

    // Trigger at cnt=40, then an ignored trigger while busy.
    wait_phase(40, 200);
    d0 = dut_dones;
    go_trig(70);
    t0 = cyc_n;
    run(5);
    go_trig(10);
    wait_idle(400);
    chk("one_done", dut_dones - d0, 1);
    chk("latency", last_done_cyc - t0, (PER - 1 - 40) + SF * PER);
    run(150);

    // One tick in four.
    en_mode = 1;
    d0 = dut_dones;
    go_trig(45);
    wait_idle(4000);
    chk("slow_done", dut_dones - d0, 1);
    run(500);

    // Full-high then full-low.
    en_mode = 0;
    go_trig(150);
    wait_idle(400);
    run(120);
    go_trig(0);
    wait_idle(400);
    run(120);

    // Random phase, values, tick pattern and overlapping triggers.
    en_mode = 2;
    for (int r = 0; r < 15; r++) begin
      run($urandom_range(0, 150));
      go_trig($urandom_range(0, 130));
      run($urandom_range(0, 50));
      go_trig($urandom_range(0, 130));
      wait_idle(3000);
    end
    en_mode = 0;
    run(100);

    // Reset in the middle of the settle wait.
    go_trig(70);
    n = 0;
    while (!(m_busy && m_bleft <= SF) && n < 500) begin cyc(); n++; end
    chk("reach_settle", m_busy && m_bleft <= SF, 1);
    run(37);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_rdy", rdy, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_pwm", pwm_out, 0);
    model_reset();
    d0 = dut_dones;
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    run(300);
    chk("no_done_after_rst", dut_dones - d0, 0);

    // Same value as the active one.
    go_trig(ROT);
`ifdef SERVO_PWM_GEN_SKIP_SAME_EN
    chk("skip_done", done, 1);
`else
    chk("noskip_done", done, 0);
`endif
    wait_idle(400);
    run(50);

    chk("done_count", dut_dones, m_dones);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
